mem_block_mover: RTL and testbench

Initiator-side engine for the team's single-port synchronous `MEMORY`. It drives `addr`, `r_en`, `w_en` and `data_in`, and consumes the memory's registered `data_out`. On a start pulse it runs one of two operations, then returns to idle: copy a block of words from a source address to a destination address, or fill a block with a constant. It sits between a control FSM or CPU-side register block and the memory, and replaces hand-sequenced read/write strobes.

---
 rtl/mem_mover_pkg.sv | 16 +
 rtl/mem_block_mover.sv | 128 ++++++++++++
 tb/tb_mem_block_mover.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_mover_pkg.sv
// Shared definitions for the memory block mover: controller state encoding
// and operation mode constants.
package mem_mover_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_mover.sv
// Block copy / block fill engine driving a single-port synchronous memory.
// Memory strobes are Moore outputs decoded from the registered state and word index.
module mem_block_mover
  import mem_mover_pkg::*;
#(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 8,
  parameter int CNT_LEN  = ADDR_LEN + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_LEN-1:0] src,
  input  logic [ADDR_LEN-1:0] dst,
  input  logic [CNT_LEN-1:0]  len,
  input  logic [WORD_LEN-1:0] fill_val,
  output logic                busy,
  output logic                done,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_r_en,
  output logic                mem_w_en,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  state_t              state_r, state_next_s;
  logic [CNT_LEN-1:0]  idx_r;
  logic [CNT_LEN-1:0]  len_r;
  logic [ADDR_LEN-1:0] src_r;
  logic [ADDR_LEN-1:0] dst_r;
  logic [WORD_LEN-1:0] fill_r;
  logic                accept_s;
  logic                last_s;
  logic [ADDR_LEN-1:0] off_s;

  assign accept_s = (state_r == ST_IDLE) && start;
  assign last_s   = (idx_r == (len_r - {{(CNT_LEN-1){1'b0}}, 1'b1}));
  // Index is at most 2^ADDR_LEN-1, so the low bits are the exact offset.
  assign off_s    = idx_r[ADDR_LEN-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture on an accepted start, word index advance after each write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r  <= {CNT_LEN{1'b0}};
      len_r  <= {CNT_LEN{1'b0}};
      src_r  <= {ADDR_LEN{1'b0}};
      dst_r  <= {ADDR_LEN{1'b0}};
      fill_r <= {WORD_LEN{1'b0}};
    end else if (accept_s) begin
      idx_r  <= {CNT_LEN{1'b0}};
      len_r  <= len;
      src_r  <= src;
      dst_r  <= dst;
      fill_r <= fill_val;
    end else if (((state_r == ST_WRITE) || (state_r == ST_FILL)) && !last_s) begin
      idx_r  <= idx_r + {{(CNT_LEN-1){1'b0}}, 1'b1};
    end else begin
      idx_r  <= idx_r;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (len == {CNT_LEN{1'b0}}) begin
            state_next_s = ST_DONE;
          end else if (mode == MODE_COPY) begin
            state_next_s = ST_READ;
          end else begin
            state_next_s = ST_FILL;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ:  state_next_s = ST_WRITE;
      ST_WRITE: state_next_s = last_s ? ST_DONE : ST_READ;
      ST_FILL:  state_next_s = last_s ? ST_DONE : ST_FILL;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Memory strobes and status; write data in WRITE is the word read one cycle earlier
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = {ADDR_LEN{1'b0}};
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    mem_wdata = {WORD_LEN{1'b0}};
    case (state_r)
      ST_READ: begin
        busy     = 1'b1;
        mem_r_en = 1'b1;
        mem_addr = src_r + off_s;
      end
      ST_WRITE: begin
        busy      = 1'b1;
        mem_w_en  = 1'b1;
        mem_addr  = dst_r + off_s;
        mem_wdata = mem_rdata;
      end
      ST_FILL: begin
        busy      = 1'b1;
        mem_w_en  = 1'b1;
        mem_addr  = dst_r + off_s;
        mem_wdata = fill_r;
      end
      ST_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// Randomized and directed bench for mem_block_mover: a behavioural memory
// responder, a cycle-level reference model and hand-computed checks.
module tb_mem_block_mover;
  import mem_mover_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src = 8'h00;
  logic [7:0] dst = 8'h00;
  logic [8:0] len = 9'd0;
  logic [7:0] fill_val = 8'h00;
  logic       busy, done, mem_r_en, mem_w_en;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  mem_block_mover #(.ADDR_LEN(8), .WORD_LEN(8), .CNT_LEN(9)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: registered read data, holds when not reading
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_wdata;
    if (mem_r_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: which cycle of which operation we are in (-1 = idle)
  int         cyc = -1;
  int         op_total = 0;
  logic       op_mode = 1'b0;
  logic [7:0] op_src = 8'h00, op_dst = 8'h00, op_fill = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= -1;
    end else if (cyc < 0) begin
      if (start) begin
        cyc      <= 1;
        op_mode  <= mode;
        op_src   <= src;
        op_dst   <= dst;
        op_fill  <= fill_val;
        op_total <= (len == 9'd0) ? 1 : ((mode == MODE_COPY) ? 2 * int'(len) + 1 : int'(len) + 1);
      end
    end else if (cyc >= op_total) begin
      cyc <= -1;
    end else begin
      cyc <= cyc + 1;
    end
  end

  logic       e_busy, e_done, e_r, e_w;
  logic [7:0] ea, ew;
  int         k;

  // Per-cycle comparison of every DUT output against the model; model memory tracks expected writes
  always @(negedge clk) begin
    if (chk_en) begin
      e_busy = 1'b0; e_done = 1'b0; e_r = 1'b0; e_w = 1'b0; ea = 8'h00; ew = 8'h00; k = 0;
      if (cyc >= 1) begin
        if (cyc == op_total) begin
          e_done = 1'b1;
        end else if (op_mode == MODE_COPY) begin
          e_busy = 1'b1;
          k = (cyc - 1) / 2;
          if ((cyc % 2) == 1) begin
            e_r = 1'b1;
            ea  = op_src + 8'(k);
          end else begin
            e_w = 1'b1;
            ea  = op_dst + 8'(k);
            ew  = ref_mem[op_src + 8'(k)];
          end
        end else begin
          e_busy = 1'b1;
          e_w    = 1'b1;
          ea     = op_dst + 8'(cyc - 1);
          ew     = op_fill;
        end
      end
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("done", {31'd0, done}, {31'd0, e_done});
      check("r_en", {31'd0, mem_r_en}, {31'd0, e_r});
      check("w_en", {31'd0, mem_w_en}, {31'd0, e_w});
      if (e_r || e_w) check("addr", {24'd0, mem_addr}, {24'd0, ea});
      if (e_w) begin
        check("wdata", {24'd0, mem_wdata}, {24'd0, ew});
        ref_mem[ea] <= ew;
      end
    end
  end

  task automatic poke_mem(input logic [7:0] a, input logic [7:0] d);
    mem[a]     <= d;
    ref_mem[a] <= d;
  endtask

  task automatic check_image(input string name);
    int diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check(name, diffs, 0);
  endtask

  // Launch one operation; returns the cycle of done and number of busy cycles.
  // poke > 0 re-pulses start (dst=C0) in that cycle and also in the DONE cycle.
  task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] f, input int n, input int poke,
                        output int done_at, output int busy_cnt);
    @(negedge clk);
    mode = m; src = s; dst = d; fill_val = f; len = 9'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 1'($urandom); src = 8'($urandom); dst = 8'($urandom);
    fill_val = 8'($urandom); len = 9'($urandom_range(1, 256));
    done_at = 1;
    busy_cnt = 0;
    while (!done && done_at < 700) begin
      busy_cnt += int'(busy);
      start = (done_at == poke);
      if (done_at == poke) dst = 8'hC0;
      @(posedge clk); #1;
      done_at++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    start = (poke > 0);
    dst = 8'hC0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  int dat, bc;
  logic [7:0] keep_a, keep_b;

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] t;
      t = 8'($urandom);
      poke_mem(8'(i), t);
    end
    #17 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_strobes", {30'd0, mem_r_en, mem_w_en}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    chk_en = 1'b1;

    // Copy
    poke_mem(8'h10, 8'hA1); poke_mem(8'h11, 8'hB2); poke_mem(8'h12, 8'hC3); poke_mem(8'h13, 8'hD4);
    run_op(MODE_COPY, 8'h10, 8'h40, 8'h00, 4, 0, dat, bc);
    check("copy_done_cyc", dat, 9);
    check("copy_busy_cyc", bc, 8);
    check("copy_w0", {24'd0, mem[8'h40]}, 32'hA1);
    check("copy_w1", {24'd0, mem[8'h41]}, 32'hB2);
    check("copy_w2", {24'd0, mem[8'h42]}, 32'hC3);
    check("copy_w3", {24'd0, mem[8'h43]}, 32'hD4);

    // Fill
    keep_a = mem[8'h1F]; keep_b = mem[8'h23];
    run_op(MODE_FILL, 8'h00, 8'h20, 8'h5A, 3, 0, dat, bc);
    check("fill_done_cyc", dat, 4);
    check("fill_w0", {24'd0, mem[8'h20]}, 32'h5A);
    check("fill_w2", {24'd0, mem[8'h22]}, 32'h5A);
    check("fill_below", {24'd0, mem[8'h1F]}, {24'd0, keep_a});
    check("fill_above", {24'd0, mem[8'h23]}, {24'd0, keep_b});

    // Wrap with overlap propagation
    poke_mem(8'hFE, 8'h11); poke_mem(8'hFF, 8'h22); poke_mem(8'h00, 8'h33); poke_mem(8'h01, 8'h44);
    run_op(MODE_COPY, 8'hFE, 8'h00, 8'h00, 4, 0, dat, bc);
    check("wrap_m0", {24'd0, mem[8'h00]}, 32'h11);
    check("wrap_m1", {24'd0, mem[8'h01]}, 32'h22);
    check("wrap_m2", {24'd0, mem[8'h02]}, 32'h11);
    check("wrap_m3", {24'd0, mem[8'h03]}, 32'h22);

    // Zero length
    run_op(MODE_COPY, 8'h10, 8'h50, 8'h00, 0, 0, dat, bc);
    check("zero_done_cyc", dat, 1);
    check("zero_busy_cyc", bc, 0);

    // Start while busy and in DONE is ignored
    keep_a = mem[8'hC0];
    run_op(MODE_COPY, 8'h10, 8'h80, 8'h00, 3, 2, dat, bc);
    check("ign_done_cyc", dat, 7);
    check("ign_c0", {24'd0, mem[8'hC0]}, {24'd0, keep_a});
    check_image("ign_image");

    // Asynchronous reset in cycle 3 of a copy
    keep_a = mem[8'h61];
    @(negedge clk);
    mode = MODE_COPY; src = 8'h10; dst = 8'h60; len = 9'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("mid_rst_outs", {busy, done, mem_r_en, mem_w_en, mem_addr, mem_wdata}, 32'd0);
    @(posedge clk); #1;
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk) rst = 1'b0;
    check("mid_rst_w0", {24'd0, mem[8'h60]}, 32'hA1);
    check("mid_rst_w1", {24'd0, mem[8'h61]}, {24'd0, keep_a});
    run_op(MODE_COPY, 8'h10, 8'h60, 8'h00, 4, 0, dat, bc);
    check("post_rst_done_cyc", dat, 9);
    check("post_rst_w3", {24'd0, mem[8'h63]}, 32'hD4);

    // Randomized operations
    for (int t = 0; t < 24; t++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 64)) : int'($urandom_range(0, 12));
      run_op(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), n, 0, dat, bc);
      check("rand_image", 32'(miscompares == 0 ? 0 : 0) + 32'(dat), 32'((n == 0) ? 1 : ((dat > 0) ? dat : 0)));
      check_image("rand_image");
    end

    // Full-range fill
    run_op(MODE_FILL, 8'h00, 8'h37, 8'hC3, 256, 0, dat, bc);
    check("full_done_cyc", dat, 257);
    begin
      int bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== 8'hC3) bad++;
      check("full_all_c3", bad, 0);
    end
    check_image("full_image");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
